// File: rtl/if_unit_pf_if.sv
// Bus bundle for the fetch stage: instruction-cache port, decode-side head
// outputs and the downstream redirect/stall controls.
interface if_unit_pf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_READ;
  logic [XLEN-1:0] IMEM_INSTR;
  logic            IMEM_BUSYWAIT;
  logic            STALL;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            ID_VALID;
  logic [XLEN-1:0] ID_PC;
  logic [XLEN-1:0] ID_INSTRUCTION;
  logic [CW-1:0]   QUEUE_COUNT;

  modport master (
    output IMEM_ADDR, IMEM_READ, ID_VALID, ID_PC, ID_INSTRUCTION, QUEUE_COUNT,
    input  IMEM_INSTR, IMEM_BUSYWAIT, STALL, REDIRECT, REDIRECT_PC
  );

  modport slave (
    input  IMEM_ADDR, IMEM_READ, ID_VALID, ID_PC, ID_INSTRUCTION, QUEUE_COUNT,
    output IMEM_INSTR, IMEM_BUSYWAIT, STALL, REDIRECT, REDIRECT_PC
  );
endinterface

// File: rtl/if_unit_pf.sv
// Instruction-fetch stage with a prefetch queue between the busywait cache and
// decode; redirects flush the queue and let an in-flight miss drain unused.
module if_unit_pf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic          CLK,
  input  logic          RESET,
  if_unit_pf_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] ins_mem_q [DEPTH];
  logic [XLEN-1:0] ins_mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            imem_read_s;
  logic            accept_s;
  logic            pop_s;
  logic            id_valid_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Request, handshake and head-of-queue decode from current state
  always_comb begin
    id_valid_s    = (count_q != {CW{1'b0}});
    redirect_pc_s = {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
    if (state_q == ST_DRAIN) begin
      imem_read_s = 1'b1;
    end else begin
      imem_read_s = (count_q < CW'(DEPTH));
    end
    accept_s = (state_q == ST_FETCH) && imem_read_s && !bus.IMEM_BUSYWAIT;
    pop_s    = id_valid_s && !bus.STALL;
  end

  assign bus.IMEM_READ      = imem_read_s & ~RESET;
  assign bus.IMEM_ADDR      = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign bus.ID_VALID       = id_valid_s;
  assign bus.ID_PC          = id_valid_s ? pc_mem_q[head_q]  : {XLEN{1'b0}};
  assign bus.ID_INSTRUCTION = id_valid_s ? ins_mem_q[head_q] : {XLEN{1'b0}};
  assign bus.QUEUE_COUNT    = count_q;

  // Next-state: redirect flush/abort first, otherwise queue push/pop and drain exit
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    pc_mem_d     = pc_mem_q;
    ins_mem_d    = ins_mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    if (bus.REDIRECT) begin
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      fetch_pc_d = redirect_pc_s;
      // A miss still owns the cache port: park its address and wait it out.
      if ((state_q == ST_FETCH) && imem_read_s && bus.IMEM_BUSYWAIT) begin
        state_d      = ST_DRAIN;
        drain_addr_d = fetch_pc_q;
      end else if ((state_q == ST_DRAIN) && !bus.IMEM_BUSYWAIT) begin
        state_d = ST_FETCH;
      end else begin
        state_d = state_q;
      end
    end else begin
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      if (accept_s) begin
        pc_mem_d[tail_q]  = fetch_pc_q;
        ins_mem_d[tail_q] = bus.IMEM_INSTR;
        tail_d            = tail_q + PW'(1);
        fetch_pc_d        = fetch_pc_q + XLEN'(4);
      end else begin
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
      end
      count_d = count_q + CW'(accept_s) - CW'(pop_s);
      case (state_q)
        ST_FETCH: state_d = ST_FETCH;
        ST_DRAIN: begin
          if (!bus.IMEM_BUSYWAIT) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= {XLEN{1'b0}};
      head_q       <= {PW{1'b0}};
      tail_q       <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= {XLEN{1'b0}};
        ins_mem_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_mem_q     <= pc_mem_d;
      ins_mem_q    <= ins_mem_d;
    end
  end
endmodule
